// File: rtl/alu_exec_unit_if.sv
// Handshake/operand bundle between the ALU control/register-read stage and the
// execute-stage ALU.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUCtrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  // Producer of operations / consumer of results.
  modport master (
    output in_valid, ALUCtrl, A, B, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  // The ALU itself.
  modport slave (
    input  in_valid, ALUCtrl, A, B, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake. Most ops complete on the accept
// edge; SLL/SRL/SRA shift one bit per cycle. Result and flags are registered and
// only change on the edge entering DONE or on reset.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSll  = 4'b0011;
  localparam logic [3:0] OpSrl  = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpAddu = 4'b1000;
  localparam logic [3:0] OpSubu = 4'b1001;
  localparam logic [3:0] OpXor  = 4'b1010;
  localparam logic [3:0] OpSltu = 4'b1011;
  localparam logic [3:0] OpNor  = 4'b1100;
  localparam logic [3:0] OpSra  = 4'b1101;
  localparam logic [3:0] OpLui  = 4'b1110;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;

  logic [WIDTH-1:0] sum, diff, alu_res, shift_next;
  logic             alu_ovf, alu_ill, is_shift;

  // Shift the in-flight value by one position according to the captured op.
  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] v);
    case (op)
      OpSll:   return {v[WIDTH-2:0], 1'b0};
      OpSra:   return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return {1'b0, v[WIDTH-1:1]};
    endcase
  endfunction

  assign sum        = bus.A + bus.B;
  assign diff       = bus.A - bus.B;
  assign shift_next = shift_one(op_q, shreg_q);
  assign is_shift   = (bus.ALUCtrl == OpSll) || (bus.ALUCtrl == OpSrl) ||
                      (bus.ALUCtrl == OpSra);

  // Single-cycle datapath on the presented operands; shifts pass B through for shamt=0.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.ALUCtrl)
      OpAnd:  alu_res = bus.A & bus.B;
      OpOr:   alu_res = bus.A | bus.B;
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OpAddu: alu_res = sum;
      OpSubu: alu_res = diff;
      OpXor:  alu_res = bus.A ^ bus.B;
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OpNor:  alu_res = ~(bus.A | bus.B);
      OpSll, OpSrl, OpSra: alu_res = bus.B;
      OpLui:  alu_res = bus.B << 16;
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state logic: accept in IDLE, iterate shifts, hold result in DONE.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (is_shift && (bus.shamt != 5'd0)) begin
            shreg_d = bus.B;
            cnt_d   = bus.shamt;
            op_d    = bus.ALUCtrl;
            state_d = StShift;
          end else begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            overflow_d = alu_ovf;
            illegal_d  = alu_ill;
            state_d    = StDone;
          end
        end
      end
      StShift: begin
        shreg_d = shift_next;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d   = shift_next;
          zero_d     = (shift_next == '0);
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; synchronous reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= 5'd0;
      op_q       <= 4'd0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.illegal   = illegal_q;

endmodule
